ode_integrator_bank: RTL



---
 rtl/ode_integrator_bank.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ode_integrator_bank.sv
// Time-multiplexed bank of fixed-point integrators: one shared Euler/trapezoid
// datapath updates CHANNELS saturating state registers, one dy sample per cycle.
module ode_integrator_bank #(
    parameter int WIDTH    = 18,
    parameter int CHANNELS = 4,
    parameter int CH_BITS  = 2,
    parameter int DELTA    = 7
) (
    input  logic                clk,
    input  logic                master_rst,
    input  logic                mode,
    input  logic                ic_load,
    input  logic [CH_BITS-1:0]  ic_ch,
    input  logic [WIDTH-1:0]    ic_value,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CH_BITS-1:0]  in_ch,
    input  logic [WIDTH-1:0]    in_dy,
    output logic                out_valid,
    output logic [CH_BITS-1:0]  out_ch,
    output logic [WIDTH-1:0]    out_y,
    output logic [CHANNELS-1:0] sat_flags
);

    // Handshake: a sample transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready is low during reset and IC loads.

    localparam int EW    = WIDTH + 2;
    localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_BITS:0]       CH_LIMIT = (CH_BITS + 1)'(CHANNELS);
    localparam logic signed [EW-1:0]   Y_MAX    = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [EW-1:0]   Y_MIN    = {3'b111, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0]    y_q       [CHANNELS];
    logic [WIDTH-1:0]    dy_prev_q [CHANNELS];
    logic [CHANNELS-1:0] sat_q;
    logic                out_valid_q;
    logic [CH_BITS-1:0]  out_ch_q;
    logic [WIDTH-1:0]    out_y_q;

    logic                in_range;
    logic                ic_in_range;
    logic                fire;
    logic [IDX_W-1:0]    in_idx;
    logic [IDX_W-1:0]    ic_idx;
    logic signed [EW-1:0] dy_ext;
    logic signed [EW-1:0] prev_ext;
    logic signed [EW-1:0] y_ext;
    logic signed [EW-1:0] inc;
    logic signed [EW-1:0] sum;
    logic [WIDTH-1:0]    y_d;
    logic                sat_d;

    assign in_ready    = ~master_rst & ~ic_load;
    assign in_range    = {1'b0, in_ch} < CH_LIMIT;
    assign ic_in_range = {1'b0, ic_ch} < CH_LIMIT;
    assign fire        = in_valid & in_ready & in_range;
    assign in_idx      = in_ch[IDX_W-1:0];
    assign ic_idx      = ic_ch[IDX_W-1:0];

    always_comb begin
        dy_ext   = {{2{in_dy[WIDTH-1]}}, in_dy};
        prev_ext = {{2{dy_prev_q[in_idx][WIDTH-1]}}, dy_prev_q[in_idx]};
        y_ext    = {{2{y_q[in_idx][WIDTH-1]}}, y_q[in_idx]};
        // Arithmetic shifts floor toward -inf, so small negative dy still moves y.
        if (mode) begin
            inc = (dy_ext + prev_ext) >>> (DELTA + 1);
        end else begin
            inc = dy_ext >>> DELTA;
        end
        sum   = y_ext + inc;
        y_d   = sum[WIDTH-1:0];
        sat_d = 1'b0;
        if (sum > Y_MAX) begin
            y_d   = Y_MAX[WIDTH-1:0];
            sat_d = 1'b1;
        end else if (sum < Y_MIN) begin
            y_d   = Y_MIN[WIDTH-1:0];
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                y_q[c]       <= '0;
                dy_prev_q[c] <= '0;
            end
            sat_q       <= '0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_y_q     <= '0;
        end else begin
            if (ic_load) begin
                if (ic_in_range) begin
                    y_q[ic_idx]       <= ic_value;
                    dy_prev_q[ic_idx] <= '0;
                    sat_q[ic_idx]     <= 1'b0;
                end
            end else if (fire) begin
                y_q[in_idx]       <= y_d;
                dy_prev_q[in_idx] <= in_dy;
                if (sat_d) begin
                    sat_q[in_idx] <= 1'b1;
                end
            end
            out_valid_q <= fire;
            if (fire) begin
                out_ch_q <= in_ch;
                out_y_q  <= y_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_y     = out_y_q;
    assign sat_flags = sat_q;

endmodule
